multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle control sequencer for the RV32I core: replaces per-instruction single-cycle decode with a Moore FSM
//  driving shared memory/ALU/regfile datapath. Supports lw, sw, R-type, beq (same subset as main decoder).
//  Sits between instruction register opcode field and datapath muxes/enables; stalls on a memory ready handshake.
// PARAMETERS
//  CNT_WIDTH     32  width of retired-instruction counter (optional feature)
//  STALL_ON_MEM  1   1: honour mem_ready; 0: treat mem_ready as constant 1
// PORTS
//  clk            in   1  clock, all state updates on rising edge
//  rst            in   1  synchronous, active-high reset
//  op             in   7  opcode from instruction register (IR[6:0])
//  Zero           in   1  ALU zero flag
//  mem_ready      in   1  memory access completes this cycle
//  PCWrite        out  1  PC register enable
//  AdrSrc         out  1  mem address: 0=PC, 1=ALUOut
//  MemWrite       out  1  memory write strobe
//  IRWrite        out  1  IR/OldPC enable
//  ResultSrc      out  2  00=ALUOut, 01=ReadData, 10=ALUResult
//  ALUSrcA        out  2  00=PC, 01=OldPC, 10=rs1 data
//  ALUSrcB        out  2  00=rs2 data, 01=ImmExt, 10=const 4
//  ALUOp          out  2  00=add, 01=sub, 10=funct-decoded
//  ImmSrc         out  2  lw 00, sw 01, beq 10, other 00 (combinational from op, every state)
//  RegWrite       out  1  regfile write enable
//  illegal_op     out  1  one-cycle pulse: unsupported opcode seen in DECODE
//  state_o        out  4  current state encoding (debug)
//  instret        out  CNT_WIDTH retired instruction count
// BEHAVIOUR
//  States (state_o): FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 ALUWB=7 BEQ=8; other codes -> FETCH.
//  Outputs Moore from state; unlisted outputs 0. rdy = mem_ready | ~STALL_ON_MEM.
//  FETCH: AdrSrc0 ALUSrcA00 ALUSrcB10 ALUOp00 ResultSrc10; IRWrite=PCWrite=rdy; rdy?DECODE:FETCH.
//  DECODE: ALUSrcA01 ALUSrcB01 ALUOp00 (branch target to ALUOut). lw/sw->MEMADR, R->EXECR, beq->BEQ,
//    else illegal_op=1, ->FETCH (no retire).
//  MEMADR: ALUSrcA10 ALUSrcB01 ALUOp00; lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: AdrSrc1; rdy?MEMWB:MEMREAD.   MEMWB: ResultSrc01 RegWrite1; ->FETCH.
//  MEMWRITE: AdrSrc1 MemWrite1 (held every wait cycle); rdy?FETCH:MEMWRITE.
//  EXECR: ALUSrcA10 ALUSrcB00 ALUOp10; ->ALUWB.   ALUWB: ResultSrc00 RegWrite1; ->FETCH.
//  BEQ: ALUSrcA10 ALUSrcB00 ALUOp01 ResultSrc00; PCWrite=Zero; ->FETCH.
//  Latency (rdy=1): lw 5, sw 4, R 4, beq 3 cycles; each wait on mem_ready adds 1 cycle in FETCH/MEMREAD/MEMWRITE.
//  op sampled from IR, stable after FETCH; FSM does not latch op.
//  Reset: while rst=1, PCWrite, IRWrite, RegWrite, MemWrite, illegal_op forced 0 same cycle; state<=FETCH,
//    instret<=0 next edge. Reset mid-access (e.g. MEMWRITE stalled) aborts: FETCH cycle after rst falls.
//  rst dominates all transitions; mem_ready ignored in states not listed as waiting.
// CONFIGURATION
//  MC_INSTRET_EN defined: instret increments by 1 on each retire (leaving MEMWB, ALUWB, BEQ, or MEMWRITE with rdy);
//    wraps modulo 2^CNT_WIDTH, no saturation.
//  MC_INSTRET_EN undefined: no counter logic; instret tied to 0.
// TESTING
//  rst=1 2 cycles, then rst=0 -> state_o=0, all enables 0 during rst, IRWrite=PCWrite=1 first cycle after.
//  lw op=0000011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; instret +1 (with _EN).
//  sw op=0100011, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH; total 7 cycles.
//  beq op=1100011 with Zero=1 then Zero=0 -> PCWrite=1 in BEQ only for first; ALUOp=01; 3 cycles each.
//  op=1111111 -> DECODE pulses illegal_op=1 one cycle, back to FETCH, instret unchanged.
//  rst asserted in MEMREAD with mem_ready=0 -> RegWrite never asserted; FETCH after rst; CNT_WIDTH=4 wraps 15->0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle Moore control sequencer for the RV32I lw/sw/R-type/beq subset.
// Define MC_INSTRET_EN to build the retired-instruction counter on instret.
module multicycle_control_fsm #(
    parameter int CNT_WIDTH    = 32,
    parameter int STALL_ON_MEM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic                 illegal_op,
    output logic [3:0]           state_o,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state;
    state_t state_nx;

    logic is_lw;
    logic is_sw;
    logic is_r;
    logic is_beq;
    logic rdy;

    logic pc_w;
    logic ir_w;
    logic mem_w;
    logic reg_w;
    logic ill;

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_beq = (op == OP_BEQ);

    // With stalling disabled the memory is assumed to answer every cycle.
    assign rdy = mem_ready | (STALL_ON_MEM == 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = S_FETCH;
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        ill       = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_w      = rdy;
                ir_w      = rdy;
                state_nx  = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (1'b1)
                    is_lw, is_sw: state_nx = S_MEMADR;
                    is_r:         state_nx = S_EXECR;
                    is_beq:       state_nx = S_BEQ;
                    default: begin
                        ill      = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                unique case (1'b1)
                    is_lw:   state_nx = S_MEMREAD;
                    is_sw:   state_nx = S_MEMWRITE;
                    default: state_nx = S_FETCH;
                endcase
            end
            S_MEMREAD: begin
                AdrSrc   = 1'b1;
                state_nx = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                state_nx  = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                mem_w    = 1'b1;
                state_nx = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b10;
                state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w    = 1'b1;
                state_nx = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                pc_w     = Zero;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        unique case (1'b1)
            is_sw:   ImmSrc = 2'b01;
            is_beq:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Architectural side effects are suppressed while reset is held.
    assign PCWrite    = pc_w  & ~rst;
    assign IRWrite    = ir_w  & ~rst;
    assign MemWrite   = mem_w & ~rst;
    assign RegWrite   = reg_w & ~rst;
    assign illegal_op = ill   & ~rst;
    assign state_o    = state;

`ifdef MC_INSTRET_EN
    logic                 retire;
    logic [CNT_WIDTH-1:0] cnt;

    assign retire = (state == S_MEMWB) |
                    (state == S_ALUWB) |
                    (state == S_BEQ) |
                    ((state == S_MEMWRITE) & rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (retire) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign instret = cnt;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm.
// Uses CNT_WIDTH=4 so counter wrap is reachable in a short run.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal_op;
    logic [3:0] state_o;
    logic [3:0] instret;
    logic [7:0] obs;

    int n_chk;
    int n_fail;

`ifdef MC_INSTRET_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif

    multicycle_control_fsm #(
        .CNT_WIDTH(4),
        .STALL_ON_MEM(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .op(op),
        .Zero(Zero),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite),
        .AdrSrc(AdrSrc),
        .MemWrite(MemWrite),
        .IRWrite(IRWrite),
        .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp),
        .ImmSrc(ImmSrc),
        .RegWrite(RegWrite),
        .illegal_op(illegal_op),
        .state_o(state_o),
        .instret(instret)
    );

    // {state, PCWrite, MemWrite, RegWrite, illegal_op}
    assign obs = {state_o, PCWrite, MemWrite, RegWrite, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        #1;
        check(tag, 32'(obs), 32'(exp));
        cyc();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        op        = 7'b0000000;
        Zero      = 1'b0;
        mem_ready = 1'b1;

        cyc();
        check("rst_en0", 32'({PCWrite, IRWrite, RegWrite, MemWrite, illegal_op}), 0);
        check("rst_st0", 32'(state_o), 0);
        cyc();
        check("rst_en1", 32'({PCWrite, IRWrite, RegWrite, MemWrite, illegal_op}), 0);
        check("rst_cnt", 32'(instret), 0);

        rst = 1'b0;
        op  = 7'b0000011;
        #1;
        check("rel_irw", 32'(IRWrite), 1);
        check("rel_srcb", 32'(ALUSrcB), 2);
        check("lw_imm", 32'(ImmSrc), 0);
        step("lw_f", 8'h08);
        check("dec_srca", 32'(ALUSrcA), 1);
        step("lw_d", 8'h10);
        step("lw_a", 8'h20);
        check("lw_adr", 32'(AdrSrc), 1);
        step("lw_r", 8'h30);
        check("lw_res", 32'(ResultSrc), 1);
        step("lw_wb", 8'h42);
        check("lw_ret", 32'(instret), EN ? 1 : 0);

        op = 7'b0100011;
        step("sw_f", 8'h08);
        check("sw_imm", 32'(ImmSrc), 1);
        step("sw_d", 8'h10);
        step("sw_a", 8'h20);
        mem_ready = 1'b0;
        step("sw_w0", 8'h54);
        step("sw_w1", 8'h54);
        step("sw_w2", 8'h54);
        mem_ready = 1'b1;
        step("sw_w3", 8'h54);
        check("sw_ret", 32'(instret), EN ? 2 : 0);

        mem_ready = 1'b0;
        step("f_stall", 8'h00);
        mem_ready = 1'b1;

        op = 7'b0110011;
        step("r_f", 8'h08);
        step("r_d", 8'h10);
        check("r_aluop", 32'(ALUOp), 2);
        check("r_srcb", 32'(ALUSrcB), 0);
        step("r_ex", 8'h60);
        step("r_wb", 8'h72);
        check("r_ret", 32'(instret), EN ? 3 : 0);

        op   = 7'b1100011;
        Zero = 1'b1;
        step("bz_f", 8'h08);
        check("beq_imm", 32'(ImmSrc), 2);
        step("bz_d", 8'h10);
        check("bz_aluop", 32'(ALUOp), 1);
        step("bz_b", 8'h88);
        Zero = 1'b0;
        step("bn_f", 8'h08);
        step("bn_d", 8'h10);
        step("bn_b", 8'h80);
        check("beq_ret", 32'(instret), EN ? 5 : 0);

        op = 7'b1111111;
        step("il_f", 8'h08);
        step("il_d", 8'h11);
        check("il_back", 32'(obs), 32'h08);
        check("il_ret", 32'(instret), EN ? 5 : 0);

        op = 7'b0000011;
        step("rr_f", 8'h08);
        step("rr_d", 8'h10);
        step("rr_a", 8'h20);
        mem_ready = 1'b0;
        step("rr_r", 8'h30);
        rst = 1'b1;
        step("rr_rst", 8'h30);
        mem_ready = 1'b1;
        step("rr_hold", 8'h00);
        rst = 1'b0;
        check("rr_cnt", 32'(instret), 0);
        step("rr_f2", 8'h08);

        op   = 7'b1100011;
        Zero = 1'b0;
        repeat (44) cyc();
        check("wrap_15", 32'(instret), EN ? 15 : 0);
        check("wrap_st", 32'(state_o), 0);
        repeat (3) cyc();
        check("wrap_0", 32'(instret), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
